// File: rtl/mul_pipe_if.sv
// Request/response bundle for mul_pipe: operand request with valid/ready in,
// product response with valid/ready out.
interface mul_pipe_if #(
    parameter int W    = 27,
    parameter int CMDW = 32
);
    logic            req;
    logic            req_rdy;
    logic [CMDW-1:0] req_command;
    logic            req_signed;
    logic [W-1:0]    req_in_1;
    logic [W-1:0]    req_in_2;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [CMDW-1:0] rsp_command;
    logic [2*W-1:0]  rsp_out;

    modport master (
        output req, req_command, req_signed, req_in_1, req_in_2, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_command, rsp_out
    );

    modport slave (
        input  req, req_command, req_signed, req_in_1, req_in_2, rsp_rdy,
        output req_rdy, rsp_vld, rsp_command, rsp_out
    );
endinterface

// File: rtl/mul_pipe.sv
// Pipelined W x W -> 2W multiplier with per-request signed mode, collapsing
// valid/ready pipeline, tag pass-through, flush and occupancy count.
module mul_pipe #(
    parameter int W      = 27,
    parameter int STAGES = 3,
    parameter int CMDW   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    mul_pipe_if.slave                     bus,
    output logic [$clog2(STAGES+1)-1:0]   cnt
);
    localparam int PW = 2 * W;
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q, v_d, adv;
    logic [CMDW-1:0]   cmd_q  [STAGES];
    logic [CMDW-1:0]   cmd_d  [STAGES];
    logic [PW-1:0]     prod_q [STAGES];
    logic [PW-1:0]     prod_d [STAGES];
    logic [W-1:0]      hi_q, hi_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     a_ext, b_ext, pp_lo, full;
    logic [W-1:0]      pp_hi;
    logic              accept, consume;

    function automatic logic [PW-1:0] extend(input logic [W-1:0] x, input logic sgn);
        return sgn ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    endfunction

    // A slot may advance if it or any slot downstream of it is empty, or the consumer is ready.
    function automatic logic [STAGES-1:0] calc_adv(input logic [STAGES-1:0] v, input logic rdy);
        logic [STAGES-1:0] a;
        logic              go;
        go = rdy;
        for (int i = STAGES - 1; i >= 0; i--) begin
            go   = go | ~v[i];
            a[i] = go;
        end
        return a;
    endfunction

    assign adv         = calc_adv(v_q, bus.rsp_rdy);
    assign bus.req_rdy = adv[0] & ~flush;
    assign accept      = bus.req & bus.req_rdy;
    assign consume     = v_q[STAGES-1] & bus.rsp_rdy & ~flush;

    assign bus.rsp_vld     = v_q[STAGES-1];
    assign bus.rsp_command = cmd_q[STAGES-1];
    assign bus.rsp_out     = prod_q[STAGES-1];
    assign cnt             = cnt_q;

    // Product mod 2^PW of the extended operands, split on the low/high half of
    // the multiplier; the high half only contributes its low W bits above bit W.
    assign a_ext = extend(bus.req_in_1, bus.req_signed);
    assign b_ext = extend(bus.req_in_2, bus.req_signed);
    assign pp_lo = a_ext * {{W{1'b0}}, b_ext[W-1:0]};
    assign pp_hi = a_ext[W-1:0] * b_ext[PW-1:W];
    assign full  = pp_lo + {pp_hi, {W{1'b0}}};

    always_comb begin
        v_d    = v_q;
        cmd_d  = cmd_q;
        prod_d = prod_q;
        hi_d   = hi_q;
        cnt_d  = cnt_q;

        for (int i = STAGES - 1; i >= 1; i--) begin
            if (adv[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    cmd_d[i]  = cmd_q[i-1];
                    prod_d[i] = (i == 1) ? prod_q[0] + {hi_q, {W{1'b0}}} : prod_q[i-1];
                end
            end
        end

        if (adv[0]) begin
            v_d[0] = accept;
            if (accept) begin
                cmd_d[0] = bus.req_command;
                if (STAGES == 1) begin
                    prod_d[0] = full;
                end else begin
                    prod_d[0] = pp_lo;
                    hi_d      = pp_hi;
                end
            end
        end

        if (accept && !consume) begin
            cnt_d = cnt_q + CW'(1);
        end else if (consume && !accept) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (flush) begin
            v_d   = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            cnt_q <= '0;
            hi_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                cmd_q[i]  <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            for (int i = 0; i < STAGES; i++) begin
                cmd_q[i]  <= cmd_d[i];
                prod_q[i] <= prod_d[i];
            end
        end
    end
endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe (W=27, STAGES=3, CMDW=32) with hand-computed products.
module tb_mul_pipe;
    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] cnt;
    int         n_checks;
    int         n_errors;

    logic [26:0] a2 [4];
    logic [26:0] b2 [4];
    logic        s2 [4];
    logic [63:0] e2 [4];

    mul_pipe_if #(.W(27), .CMDW(32)) bus();

    mul_pipe #(.W(27), .STAGES(3), .CMDW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .cnt   (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] c, input logic s, input logic [26:0] a, input logic [26:0] b);
        bus.req         = 1'b1;
        bus.req_command = c;
        bus.req_signed  = s;
        bus.req_in_1    = a;
        bus.req_in_2    = b;
    endtask

    task automatic idle();
        bus.req = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] c, input logic [63:0] p);
        check_eq({tag, "_vld"}, 64'(bus.rsp_vld), 64'd1);
        check_eq({tag, "_cmd"}, 64'(bus.rsp_command), 64'(c));
        check_eq({tag, "_out"}, 64'(bus.rsp_out), p);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        a2[0] = 27'h7FFFFFF; b2[0] = 27'h7FFFFFF; s2[0] = 1'b1; e2[0] = 64'h00000000000001;
        a2[1] = 27'h4000000; b2[1] = 27'h4000000; s2[1] = 1'b1; e2[1] = 64'h10000000000000;
        a2[2] = 27'h7FFFFFF; b2[2] = 27'h0000002; s2[2] = 1'b1; e2[2] = 64'h3FFFFFFFFFFFFE;
        a2[3] = 27'h7FFFFFF; b2[3] = 27'h0000002; s2[3] = 1'b0; e2[3] = 64'h0000000FFFFFFE;

        reset           = 1'b0;
        flush           = 1'b0;
        bus.req         = 1'b0;
        bus.req_command = '0;
        bus.req_signed  = 1'b0;
        bus.req_in_1    = '0;
        bus.req_in_2    = '0;
        bus.rsp_rdy     = 1'b0;

        // Reset state
        #12;
        check_eq("rst_vld", 64'(bus.rsp_vld), 64'd0);
        check_eq("rst_cnt", 64'(cnt), 64'd0);
        check_eq("rst_out", 64'(bus.rsp_out), 64'd0);
        check_eq("rst_cmd", 64'(bus.rsp_command), 64'd0);
        #1 reset = 1'b1;
        step();
        check_eq("rst_rdy", 64'(bus.req_rdy), 64'd1);

        // Unsigned max, latency
        bus.rsp_rdy = 1'b1;
        issue(32'd5, 1'b0, 27'h7FFFFFF, 27'h7FFFFFF);
        step();
        idle();
        check_eq("lat_e0", 64'(bus.rsp_vld), 64'd0);
        check_eq("lat_cnt", 64'(cnt), 64'd1);
        step();
        check_eq("lat_e1", 64'(bus.rsp_vld), 64'd0);
        step();
        check_rsp("umax", 32'd5, 64'h3FFFFFF0000001);
        step();
        check_eq("umax_drain", 64'(bus.rsp_vld), 64'd0);
        check_eq("umax_cnt", 64'(cnt), 64'd0);

        // Signed/unsigned corners back-to-back
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) issue(32'(10 + cyc), s2[cyc], a2[cyc], b2[cyc]);
            else idle();
            step();
            if (cyc >= 2) check_rsp("b2b", 32'(10 + cyc - 2), e2[cyc-2]);
        end
        step();
        check_eq("b2b_end", 64'(bus.rsp_vld), 64'd0);

        // Backpressure: fill, stall, accept-and-drain
        bus.rsp_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            issue(32'(c), 1'b0, 27'(c + 1), 27'd3);
            #1;
            check_eq("bp_rdy_fill", 64'(bus.req_rdy), 64'd1);
            step();
        end
        issue(32'd3, 1'b0, 27'd4, 27'd3);
        #1;
        check_eq("bp_rdy_full", 64'(bus.req_rdy), 64'd0);
        check_eq("bp_cnt_full", 64'(cnt), 64'd3);
        check_rsp("bp_head", 32'd0, 64'd3);
        step();
        check_eq("bp_cnt_hold", 64'(cnt), 64'd3);
        check_rsp("bp_hold", 32'd0, 64'd3);
        bus.rsp_rdy = 1'b1;
        #1;
        check_eq("bp_rdy_drain", 64'(bus.req_rdy), 64'd1);
        step();
        idle();
        check_eq("bp_cnt_a", 64'(cnt), 64'd3);
        check_rsp("bp_r1", 32'd1, 64'd6);
        step();
        check_eq("bp_cnt_b", 64'(cnt), 64'd2);
        check_rsp("bp_r2", 32'd2, 64'd9);
        step();
        check_eq("bp_cnt_c", 64'(cnt), 64'd1);
        check_rsp("bp_r3", 32'd3, 64'd12);
        step();
        check_eq("bp_cnt_d", 64'(cnt), 64'd0);
        check_eq("bp_vld_d", 64'(bus.rsp_vld), 64'd0);

        // Bubble collapse
        bus.rsp_rdy = 1'b0;
        issue(32'hA, 1'b0, 27'd5, 27'd7);
        step();
        idle();
        step();
        issue(32'hB, 1'b0, 27'd6, 27'd7);
        step();
        idle();
        step();
        check_eq("bub_cnt", 64'(cnt), 64'd2);
        check_eq("bub_rdy", 64'(bus.req_rdy), 64'd1);
        check_rsp("bub_a", 32'hA, 64'd35);
        bus.rsp_rdy = 1'b1;
        step();
        check_rsp("bub_b", 32'hB, 64'd42);
        step();
        check_eq("bub_end", 64'(bus.rsp_vld), 64'd0);
        check_eq("bub_cnt_end", 64'(cnt), 64'd0);

        // Flush with three ops in flight
        for (int c = 20; c < 23; c++) begin
            issue(32'(c), 1'b0, 27'(c), 27'd2);
            step();
        end
        issue(32'd23, 1'b0, 27'd1, 27'd1);
        flush = 1'b1;
        #1;
        check_eq("fl_rdy", 64'(bus.req_rdy), 64'd0);
        check_rsp("fl_head", 32'd20, 64'd40);
        step();
        flush = 1'b0;
        idle();
        check_eq("fl_vld", 64'(bus.rsp_vld), 64'd0);
        check_eq("fl_cnt", 64'(cnt), 64'd0);
        issue(32'd24, 1'b1, 27'h7FFFFFF, 27'd3);
        step();
        idle();
        check_eq("fl_cnt_new", 64'(cnt), 64'd1);
        step();
        check_eq("fl_vld_early", 64'(bus.rsp_vld), 64'd0);
        step();
        check_rsp("fl_new", 32'd24, 64'h3FFFFFFFFFFFFD);
        step();
        check_eq("fl_end", 64'(bus.rsp_vld), 64'd0);

        // Asynchronous reset mid-operation
        bus.rsp_rdy = 1'b0;
        issue(32'd30, 1'b0, 27'd2, 27'd2);
        step();
        issue(32'd31, 1'b0, 27'd3, 27'd3);
        step();
        idle();
        check_eq("ar_cnt_pre", 64'(cnt), 64'd2);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_vld", 64'(bus.rsp_vld), 64'd0);
        check_eq("ar_cnt", 64'(cnt), 64'd0);
        check_eq("ar_out", 64'(bus.rsp_out), 64'd0);
        #2 reset = 1'b1;
        bus.rsp_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("ar_stale", 64'(bus.rsp_vld), 64'd0);
        end
        check_eq("ar_cnt_end", 64'(cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, fully pipelined integer multiplier. Successor to the fixed 27x27 single-purpose multiplier stage in the fma datapath.
- Adds configurable operand width and pipeline depth, a per-request signed/unsigned mode, valid/ready backpressure with bubble collapse, command-tag pass-through, flush, and occupancy reporting.
- Sits between the fma request front-end and the add/align stage.

Parameters:
- W, 27, operand width in bits (product is 2W).
- STAGES, 3, pipeline depth (1..4); latency in cycles when not stalled.
- CMDW, 32, width of the command tag carried alongside each operation.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- req  in  1  request valid.
- req_rdy  out  1  request accepted when req && req_rdy.
- req_command  in  CMDW  tag, returned unchanged with the result.
- req_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- req_in_1  in  W  multiplicand.
- req_in_2  in  W  multiplier.
- rsp_vld  out  1  result valid.
- rsp_rdy  in  1  consumer ready; result consumed when rsp_vld && rsp_rdy.
- rsp_command  out  CMDW  tag of the presented result.
- rsp_out  out  2W  product.
- cnt  out  $clog2(STAGES+1)  number of occupied stages.

Behaviour:
- Reset (reset low, asynchronous): all stage valid bits clear; rsp_vld=0, cnt=0, rsp_out=0, rsp_command=0; req_rdy=1 once reset deasserts. Reset mid-operation discards all in-flight work with no output.
- Pipeline: STAGES register slots s[0..STAGES-1], each holding a valid bit, tag, and partial/final product state. s[STAGES-1] drives rsp_*.
- Internal split of the multiply across stages is free. Only the output value and timing below are specified.
- Advance rule: adv[STAGES-1] = !v[STAGES-1] || rsp_rdy; adv[i] = !v[i] || adv[i+1]. A slot loads from its predecessor when adv[i]; the predecessor's valid clears if it is not refilled.
- Bubbles collapse: an empty slot ahead of a stalled slot still fills.
- req_rdy = adv[0] && !flush (combinational from rsp_rdy).
- Latency: with rsp_rdy held 1, a request accepted at edge N gives rsp_vld=1 after edge N+STAGES-1 (visible in cycle N+STAGES-1..N+STAGES). Throughput is 1 per cycle.
- Ordering: strictly in order; tag and product stay paired.
- Arithmetic:
  - Signed mode: both operands sign-extended to 2W; rsp_out = low 2W bits of the product.
  - Unsigned mode: zero-extend both operands.
  - Mode is captured per request at acceptance.
  - No overflow is possible; the full 2W result is always exact.
- Stall: while rsp_vld && !rsp_rdy, rsp_out and rsp_command hold stable.
- Full: all slots valid and rsp_rdy=0 gives req_rdy=0 and cnt=STAGES. A simultaneous rsp_rdy=1 gives req_rdy=1 (accept and drain in the same cycle).
- cnt = registered count of valid slots. +1 on accept, -1 on consume, unchanged on both. Must equal the popcount of the valid bits every cycle.
- Flush:
  - On an edge with flush=1, all valid bits clear and cnt=0.
  - req_rdy=0 during flush, so no accept; a result presented that cycle is not consumed even if rsp_rdy=1.
  - Flush has priority over accept and consume.
- Outputs are driven from registers except req_rdy. No combinational path from req_in_* to rsp_*.
- STAGES=1: the single slot is the output register; the advance rule is unchanged.

Test Plan (W=27, STAGES=3, CMDW=32):
- Unsigned max: in_1=in_2=0x7FFFFFF, signed=0, cmd=5, rsp_rdy=1 -> rsp_vld 3 cycles after accept, rsp_out=0x3FFFFFF0000001, rsp_command=5.
- Signed corner cases, back-to-back:
  - 0x7FFFFFF*0x7FFFFFF -> 0x00000000000001.
  - 0x4000000*0x4000000 -> 0x10000000000000.
  - 0x7FFFFFF*0x0000002 -> 0x3FFFFFFFFFFFFE.
  - Same last pair with signed=0 -> 0x00000000FFFFFFE.
  - Results appear on consecutive cycles.
- Backpressure: issue cmds 0..3 every cycle with rsp_rdy=0 -> only 0..2 accepted, req_rdy=0, cnt=3, rsp_out held stable. Raise rsp_rdy -> cmd 3 accepted the same cycle, results 0,1,2,3 drain one per cycle, cnt returns to 0.
- Bubble collapse: accept cmd A, idle one cycle, accept B, rsp_rdy=0 -> A and B end in s[2] and s[1] with cnt=2 and req_rdy=1; then rsp_rdy=1 -> A, B on consecutive cycles.
- Flush: 3 ops in flight, flush=1 with req=1 and rsp_rdy=1 -> no accept, no consume, next cycle rsp_vld=0, cnt=0; ops issued after flush return with correct products.
- Async reset: assert reset low between edges with 2 ops in flight -> rsp_vld and cnt go to 0 immediately without a clock edge; no stale results appear after release.
